// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I/RV64I immediate decode with pc+imm target behind a 2-entry skid buffer
// in_ready is derived only from the skid flag, so consumer stalls never reach fetch combinationally.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_immsel,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_immsel
);

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] tgt_d;
  logic            skd_valid;
  logic [XLEN-1:0] skd_imm;
  logic [XLEN-1:0] skd_target;
  logic [2:0]      skd_immsel;
  logic            accept;
  logic            unused_opcode;

  // Opcode bits never carry immediate data.
  assign unused_opcode = ^in_inst[6:0];

  // Start from the sign fill, then overlay the format's low bits.
  always_comb begin
    imm_d = '0;
    case (in_immsel)
      3'd0: begin
        imm_d       = {XLEN{in_inst[31]}};
        imm_d[10:0] = in_inst[30:20];
      end
      3'd1: begin
        imm_d       = {XLEN{in_inst[31]}};
        imm_d[10:0] = {in_inst[30:25], in_inst[11:7]};
      end
      3'd2: begin
        imm_d       = {XLEN{in_inst[31]}};
        imm_d[11:0] = {in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      3'd3: begin
        imm_d       = {XLEN{in_inst[31]}};
        imm_d[31:0] = {in_inst[31:12], 12'b0};
      end
      3'd4: begin
        imm_d       = {XLEN{in_inst[31]}};
        imm_d[19:0] = {in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      3'd5: imm_d[4:0] = in_inst[19:15];
      3'd6: begin
        if (XLEN == 64) imm_d[5:0] = in_inst[25:20];
        else            imm_d[4:0] = in_inst[24:20];
      end
      default: imm_d = '0;
    endcase
  end

  assign tgt_d    = in_pc + imm_d;
  assign in_ready = ~skd_valid & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_target <= '0;
      out_immsel <= '0;
      skd_valid  <= 1'b0;
      skd_imm    <= '0;
      skd_target <= '0;
      skd_immsel <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skd_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // OUT is free this cycle: the skid entry is older than any new input.
      if (skd_valid) begin
        out_valid  <= 1'b1;
        out_imm    <= skd_imm;
        out_target <= skd_target;
        out_immsel <= skd_immsel;
        skd_valid  <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_imm    <= imm_d;
        out_target <= tgt_d;
        out_immsel <= in_immsel;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skd_valid  <= 1'b1;
      skd_imm    <= imm_d;
      skd_target <= tgt_d;
      skd_immsel <= in_immsel;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench driving XLEN=32 and XLEN=64 instances with shared stimulus against a queue model
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [2:0]  in_immsel = '0;
  logic [63:0] in_pc = '0;

  logic        r32, v32, r64, v64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;
  logic [2:0]  sel32, sel64;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_inst(in_inst), .in_immsel(in_immsel), .in_pc(in_pc[31:0]),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32), .out_immsel(sel32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_inst(in_inst), .in_immsel(in_immsel), .in_pc(in_pc),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64), .out_immsel(sel64)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate value as a signed integer built from field weights.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] sel, input bit x64);
    longint si;
    longint v;
    si = $signed(i);
    case (sel)
      3'd0: v = si >>> 20;
      3'd1: v = (si >>> 25) * 32 + longint'(i[11:7]);
      3'd2: v = (si >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      3'd3: v = (si >>> 12) * 4096;
      3'd4: v = (si >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      3'd5: v = longint'(i[19:15]);
      3'd6: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    bit          exp_v;
    bit          exp_rdy;
    ent_t        e;
    logic [63:0] e64;
    logic [63:0] e32;
    logic [31:0] t32;
    exp_v   = (q.size() > 0);
    exp_rdy = !rst && !flush && (q.size() < 2);
    chk("in_ready32", {63'b0, r32}, {63'b0, exp_rdy});
    chk("in_ready64", {63'b0, r64}, {63'b0, exp_rdy});
    chk("out_valid32", {63'b0, v32}, {63'b0, exp_v});
    chk("out_valid64", {63'b0, v64}, {63'b0, exp_v});
    if (exp_v) begin
      e   = q[0];
      e64 = ref_imm(e.inst, e.sel, 1'b1);
      e32 = ref_imm(e.inst, e.sel, 1'b0);
      t32 = e.pc[31:0] + e32[31:0];
      chk("imm64", imm64, e64);
      chk("target64", tgt64, e.pc + e64);
      chk("sel64", {61'b0, sel64}, {61'b0, e.sel});
      chk("imm32", {32'b0, imm32}, {32'b0, e32[31:0]});
      chk("target32", {32'b0, tgt32}, {32'b0, t32});
      chk("sel32", {61'b0, sel32}, {61'b0, e.sel});
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      if (exp_v && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back({in_inst, in_immsel, in_pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] inst, input logic [2:0] sel, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_immsel = sel;
    in_pc     = pc;
  endtask

  logic [31:0] sw_inst [7];
  logic [2:0]  sw_sel  [7];

  initial begin
    int k;
    sw_inst = '{32'h60010113, 32'h00e12423, 32'h00208863, 32'h005412b7, 32'h00c000ef, 32'h51e0d073, 32'h003100b3};
    sw_sel  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid64", {63'b0, v64}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_target64", tgt64, 64'd0);
    chk("rst_sel64", {61'b0, sel64}, 64'd0);
    chk("rst_imm32", {32'b0, imm32}, 64'd0);
    chk("rst_ready64", {63'b0, r64}, 64'd0);

    chk("pin_I", ref_imm(32'h60010113, 3'd0, 1'b1), 64'h600);
    chk("pin_S", ref_imm(32'h00e12423, 3'd1, 1'b1), 64'h8);
    chk("pin_B", 64'h100 + ref_imm(32'h00208863, 3'd2, 1'b1), 64'h110);
    chk("pin_U", ref_imm(32'h005412b7, 3'd3, 1'b1), 64'h541000);
    chk("pin_J", 64'h100 + ref_imm(32'h00c000ef, 3'd4, 1'b1), 64'h10c);
    chk("pin_Z", ref_imm(32'h51e0d073, 3'd5, 1'b1), 64'h1);
    chk("pin_I_neg", ref_imm(32'hfff00093, 3'd0, 1'b1), 64'hffffffffffffffff);
    chk("pin_J_wrap", 64'h10 + ref_imm(32'hfe1ff06f, 3'd4, 1'b1), 64'hfffffffffffffff0);
    chk("pin_sh64", ref_imm(32'h03f01013, 3'd6, 1'b1), 64'd63);
    chk("pin_sh32", ref_imm(32'h03f01013, 3'd6, 1'b0), 64'd31);

    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put(sw_inst[i], sw_sel[i], 64'h100);
      tick();
    end
    put(32'hfff00093, 3'd0, 64'h100); tick();
    put(32'hfe1ff06f, 3'd4, 64'h10);  tick();
    put(32'h03f01013, 3'd6, 64'h100); tick();
    in_valid = 1'b0;
    repeat (2) tick();

    out_ready = 1'b0;
    put(32'h00100093, 3'd0, 64'h200); tick();
    put(32'h00208863, 3'd2, 64'h204); tick();
    chk("bp_ready_low", {63'b0, r64}, 64'd0);
    put(32'h00c000ef, 3'd4, 64'h208); tick();
    out_ready = 1'b1;
    k = 0;
    while (!r64 && k < 10) begin
      tick();
      k++;
    end
    chk("bp_ready_bound", {63'b0, (k < 10)}, 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    out_ready = 1'b0;
    put(32'h00500093, 3'd0, 64'h300); tick();
    put(32'h00600093, 3'd0, 64'h304); tick();
    flush = 1'b1;
    put(32'h7ff00093, 3'd0, 64'h308); tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid", {63'b0, v64}, 64'd0);
    chk("flush_ready", {63'b0, r64}, 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();

    out_ready = 1'b0;
    put(32'hfff00093, 3'd0, 64'h400); tick();
    put(32'h00c000ef, 3'd4, 64'h404); tick();
    rst = 1'b1;
    flush = 1'b1;
    put(32'h00100093, 3'd0, 64'h408); tick();
    chk("mid_rst_valid", {63'b0, v64}, 64'd0);
    chk("mid_rst_imm", imm64, 64'd0);
    chk("mid_rst_target", tgt64, 64'd0);
    chk("mid_rst_sel", {61'b0, sel64}, 64'd0);
    chk("mid_rst_ready", {63'b0, r64}, 64'd0);
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_ready", {63'b0, r64}, 64'd1);
    tick();

    for (int i = 0; i < 10000; i++) begin
      rst       = ($urandom % 500) == 0;
      flush     = ($urandom % 64) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_inst   = $urandom;
      in_immsel = 3'($urandom % 8);
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
